// File: rtl/ssr_pkg.sv
// Shared types for the shift/set/reset operand register: command codes and FSM states.
package ssr_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_CLR  = 3'b100,
    OP_SET  = 3'b101,
    OP_SAR  = 3'b110,
    OP_ROL  = 3'b111
  } ssr_op_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ssr_state_t;

endpackage

// File: rtl/ssr_step.sv
// One-position shift/rotate datapath; produces the next register value and the bit that leaves.
module ssr_step
  import ssr_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] value,
  input  ssr_op_t          op,
  input  logic             fill,
  output logic [WIDTH-1:0] next_value,
  output logic             shift_out
);

  always_comb begin
    next_value = value;
    shift_out  = 1'b0;
    case (op)
      OP_SHL: begin
        next_value = {value[WIDTH-2:0], fill};
        shift_out  = value[WIDTH-1];
      end
      OP_SHR: begin
        next_value = {fill, value[WIDTH-1:1]};
        shift_out  = value[0];
      end
      OP_SAR: begin
        next_value = {value[WIDTH-1], value[WIDTH-1:1]};
        shift_out  = value[0];
      end
      OP_ROL: begin
        next_value = {value[WIDTH-2:0], value[WIDTH-1]};
        shift_out  = value[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_set_reg.sv
// Operand register with load, single-bit clear/set and iterative one-bit-per-cycle shifts.
module shift_set_reg
  import ssr_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             fill,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ready,
  output logic             done,
  output logic             carry
);

  ssr_state_t       state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  ssr_op_t          op_q, op_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] step_value;
  logic             step_out;
  logic [WIDTH-1:0] bit_mask;

  // An index past the top bit shifts the one out entirely, so CLR/SET become no-ops.
  assign bit_mask = WIDTH'(1) << amt;

  ssr_step #(.WIDTH(WIDTH)) u_step (
    .value      (data_q),
    .op         (op_q),
    .fill       (fill_q),
    .next_value (step_value),
    .shift_out  (step_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    data_d  = data_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = ssr_op_t'(op);
          fill_d = fill;
          done_d = 1'b1;
          case (ssr_op_t'(op))
            OP_LOAD: data_d = data_in;
            OP_CLR:  data_d = data_q & ~bit_mask;
            OP_SET:  data_d = data_q | bit_mask;
            OP_SHL, OP_SHR, OP_SAR, OP_ROL: begin
              if (amt == '0) begin
                carry_d = 1'b0;
              end else begin
                done_d  = 1'b0;
                cnt_d   = amt;
                state_d = ST_SHIFT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_SHIFT: begin
        data_d  = step_value;
        carry_d = step_out;
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NOP;
      fill_q  <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign carry    = carry_q;

endmodule

// File: tb/tb_shift_set_reg.sv
// Directed bench for shift_set_reg at WIDTH=8: command table plus reset/ignore/back-to-back sequences.
module tb_shift_set_reg;
  import ssr_pkg::*;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;
  localparam int MAX_WAIT = 40;

  logic             clk;
  logic             rst;
  logic             start;
  logic [2:0]       op;
  logic [AMT_W-1:0] amt;
  logic             fill;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             ready;
  logic             done;
  logic             carry;

  typedef struct {
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             fill;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] exp_data;
    logic             exp_carry;
    int               exp_lat;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int n_compared;
  int n_mismatched;
  int obs_lat;
  int obs_ready_low;

  shift_set_reg #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .amt      (amt),
    .fill     (fill),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .done     (done),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [2:0] o, input logic [AMT_W-1:0] a, input logic f,
                              input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ed,
                              input logic ec, input int lat);
    vec_t v;
    v.op = o; v.amt = a; v.fill = f; v.din = d;
    v.exp_data = ed; v.exp_carry = ec; v.exp_lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one command and waits (bounded) for its done pulse, recording latency and busy cycles.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start = 1'b1; op = v.op; amt = v.amt; fill = v.fill; data_in = v.din;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    fill = ~v.fill;
    obs_lat = 1;
    obs_ready_low = 0;
    while (!done && obs_lat < MAX_WAIT) begin
      if (!ready) obs_ready_low++;
      @(negedge clk);
      obs_lat++;
    end
  endtask

  initial begin
    int seen_done;
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b1; start = 1'b0; op = 3'b000; amt = '0; fill = 1'b0; data_in = '0;

    vecs[0]  = mk(OP_LOAD, 3'd0, 1'b0, 8'hB4, 8'hB4, 1'b0, 1);
    vecs[1]  = mk(OP_SHL,  3'd3, 1'b1, 8'h00, 8'hA7, 1'b1, 4);
    vecs[2]  = mk(OP_LOAD, 3'd0, 1'b0, 8'h00, 8'h00, 1'b1, 1);
    vecs[3]  = mk(OP_SET,  3'd7, 1'b0, 8'h00, 8'h80, 1'b1, 1);
    vecs[4]  = mk(OP_LOAD, 3'd0, 1'b0, 8'hFF, 8'hFF, 1'b1, 1);
    vecs[5]  = mk(OP_CLR,  3'd0, 1'b0, 8'h00, 8'hFE, 1'b1, 1);
    vecs[6]  = mk(OP_NOP,  3'd2, 1'b1, 8'h33, 8'hFE, 1'b1, 1);
    vecs[7]  = mk(OP_LOAD, 3'd0, 1'b0, 8'h90, 8'h90, 1'b1, 1);
    vecs[8]  = mk(OP_SAR,  3'd2, 1'b1, 8'h00, 8'hE4, 1'b0, 3);
    vecs[9]  = mk(OP_LOAD, 3'd0, 1'b0, 8'h90, 8'h90, 1'b0, 1);
    vecs[10] = mk(OP_SHR,  3'd2, 1'b0, 8'h00, 8'h24, 1'b0, 3);
    vecs[11] = mk(OP_LOAD, 3'd0, 1'b0, 8'h03, 8'h03, 1'b0, 1);
    vecs[12] = mk(OP_SHR,  3'd1, 1'b1, 8'h00, 8'h81, 1'b1, 2);
    vecs[13] = mk(OP_LOAD, 3'd0, 1'b0, 8'h81, 8'h81, 1'b1, 1);
    vecs[14] = mk(OP_ROL,  3'd3, 1'b1, 8'h00, 8'h0C, 1'b0, 4);
    vecs[15] = mk(OP_LOAD, 3'd0, 1'b0, 8'h80, 8'h80, 1'b0, 1);
    vecs[16] = mk(OP_ROL,  3'd1, 1'b0, 8'h00, 8'h01, 1'b1, 2);
    vecs[17] = mk(OP_LOAD, 3'd0, 1'b0, 8'h5A, 8'h5A, 1'b1, 1);
    vecs[18] = mk(OP_SHL,  3'd0, 1'b1, 8'h00, 8'h5A, 1'b0, 1);
    vecs[19] = mk(OP_SHL,  3'd7, 1'b0, 8'h00, 8'h00, 1'b1, 8);
    vecs[20] = mk(OP_LOAD, 3'd0, 1'b0, 8'h80, 8'h80, 1'b1, 1);
    vecs[21] = mk(OP_SAR,  3'd7, 1'b0, 8'h00, 8'hFF, 1'b0, 8);
    vecs[22] = mk(OP_LOAD, 3'd0, 1'b0, 8'h40, 8'h40, 1'b0, 1);
    vecs[23] = mk(OP_SAR,  3'd1, 1'b1, 8'h00, 8'h20, 1'b0, 2);

    #12;
    checkOutput("reset data_out", 32'(data_out), 32'h00);
    checkOutput("reset ready", 32'(ready), 32'h1);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset carry", 32'(carry), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d latency", i), 32'(obs_lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d ready-low cycles", i), 32'(obs_ready_low), 32'(vecs[i].exp_lat - 1));
      checkOutput($sformatf("v%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      checkOutput($sformatf("v%0d carry", i), 32'(carry), 32'(vecs[i].exp_carry));
      checkOutput($sformatf("v%0d ready at done", i), 32'(ready), 32'h1);
    end

    // Start pulses during a shift must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; op = OP_LOAD; data_in = 8'h0F;
    @(negedge clk);
    op = OP_SHL; amt = 3'd3; fill = 1'b0;
    @(negedge clk);
    op = OP_LOAD; data_in = 8'hAA;
    checkOutput("busy ready", 32'(ready), 32'h0);
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checkOutput("ignored-start done count", 32'(seen_done), 32'h1);
    checkOutput("ignored-start data_out", 32'(data_out), 32'h78);
    checkOutput("ignored-start carry", 32'(carry), 32'h0);

    // Asynchronous reset in the middle of a shift.
    start = 1'b1; op = OP_LOAD; data_in = 8'hFF;
    @(negedge clk);
    op = OP_SHL; amt = 3'd5; fill = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre-reset data_out", 32'(data_out), 32'hFC);
    checkOutput("pre-reset carry", 32'(carry), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid-shift reset data_out", 32'(data_out), 32'h00);
    checkOutput("mid-shift reset ready", 32'(ready), 32'h1);
    checkOutput("mid-shift reset done", 32'(done), 32'h0);
    checkOutput("mid-shift reset carry", 32'(carry), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checkOutput("post-reset done count", 32'(seen_done), 32'h0);
    checkOutput("post-reset data_out", 32'(data_out), 32'h00);

    // Back-to-back: LOAD, SET, then SHL issued in SET's done cycle.
    start = 1'b1; op = OP_LOAD; data_in = 8'h01;
    @(negedge clk);
    checkOutput("b2b load done", 32'(done), 32'h1);
    checkOutput("b2b load data_out", 32'(data_out), 32'h01);
    op = OP_SET; amt = 3'd4;
    @(negedge clk);
    checkOutput("b2b set done", 32'(done), 32'h1);
    checkOutput("b2b set data_out", 32'(data_out), 32'h11);
    checkOutput("b2b set ready", 32'(ready), 32'h1);
    op = OP_SHL; amt = 3'd1; fill = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b shl busy done", 32'(done), 32'h0);
    checkOutput("b2b shl busy ready", 32'(ready), 32'h0);
    @(negedge clk);
    checkOutput("b2b shl done", 32'(done), 32'h1);
    checkOutput("b2b shl data_out", 32'(data_out), 32'h22);
    checkOutput("b2b shl carry", 32'(carry), 32'h0);
    @(negedge clk);
    checkOutput("b2b done pulse width", 32'(done), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
